// File: rtl/write_back_if.sv
// write_back bundle: retiring-instruction fields and UART rx in, regfile/redirect/status out.
// Latency: none; this is a plain signal bundle.
// Backpressure: uart_rx_valid/uart_rx_ready handshake, and done gates upstream valid.
interface write_back_if #(
    parameter int INST_MEM_WIDTH = 2
);
    logic                      valid;
    logic                      distinct;
    logic                      AorF;
    logic                      RegWrite;
    logic [1:0]                MemtoReg;
    logic [1:0]                Branch;
    logic                      UARTtoReg;
    logic [31:0]               read_data;
    logic [31:0]               register_data;
    logic [31:0]               alu_result;
    logic [4:0]                rdist;
    logic [25:0]               inst_index;
    logic [INST_MEM_WIDTH-1:0] pc;
    logic [INST_MEM_WIDTH-1:0] pc1;
    logic [INST_MEM_WIDTH-1:0] pc2;
    logic                      uart_rx_valid;
    logic [7:0]                uart_rx_data;
    logic                      uart_rx_ready;
    logic                      reg_we_int;
    logic                      reg_we_fp;
    logic [4:0]                reg_waddr;
    logic [31:0]               reg_wdata;
    logic                      pc_redirect;
    logic [INST_MEM_WIDTH-1:0] pc_target;
    logic                      done;
    logic                      busy;
    logic                      uart_timeout;

    // Upstream / environment side.
    modport master (
        output valid, distinct, AorF, RegWrite, MemtoReg, Branch, UARTtoReg,
               read_data, register_data, alu_result, rdist, inst_index, pc, pc1, pc2,
               uart_rx_valid, uart_rx_data,
        input  uart_rx_ready, reg_we_int, reg_we_fp, reg_waddr, reg_wdata,
               pc_redirect, pc_target, done, busy, uart_timeout
    );

    // write_back stage side.
    modport slave (
        input  valid, distinct, AorF, RegWrite, MemtoReg, Branch, UARTtoReg,
               read_data, register_data, alu_result, rdist, inst_index, pc, pc1, pc2,
               uart_rx_valid, uart_rx_data,
        output uart_rx_ready, reg_we_int, reg_we_fp, reg_waddr, reg_wdata,
               pc_redirect, pc_target, done, busy, uart_timeout
    );
endinterface

// File: rtl/write_back.sv
// write_back: final stage; selects write-back data, strobes int/FP regfile, resolves PC redirect.
// Latency: valid at t -> COMMIT (done/strobes) at t+1; UART handshake at u -> COMMIT at u+1.
// Backpressure: UART reads park in UART_WAIT with uart_rx_ready high; valid while busy is ignored.
// Optional macro WB_UART_TIMEOUT_EN bounds UART_WAIT by UART_TIMEOUT_CYCLES and sets sticky uart_timeout.
module write_back #(
    parameter int INST_MEM_WIDTH      = 2,
    parameter int UART_TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        reset,
    write_back_if.slave wb
);
    localparam int IMW = INST_MEM_WIDTH;

    typedef enum logic [1:0] {IDLE, UART_WAIT, COMMIT} state_t;

    typedef struct packed {
        logic           distinct;
        logic           aorf;
        logic           reg_write;
        logic [1:0]     mem_to_reg;
        logic [1:0]     branch;
        logic           uart_to_reg;
        logic [31:0]    read_data;
        logic [31:0]    register_data;
        logic [31:0]    alu_result;
        logic [4:0]     rdist;
        logic [25:0]    inst_index;
        logic [IMW-1:0] pc1;
        logic [IMW-1:0] pc2;
    } bundle_t;

    state_t         state_q, state_d;
    bundle_t        bundle_q, bundle_d;
    bundle_t        live, cur;
    logic           commit_go;
    logic [31:0]    uart_word;
    logic           reg_we_int_q, reg_we_int_d;
    logic           reg_we_fp_q, reg_we_fp_d;
    logic [4:0]     reg_waddr_q, reg_waddr_d;
    logic [31:0]    reg_wdata_q, reg_wdata_d;
    logic           pc_redirect_q, pc_redirect_d;
    logic [IMW-1:0] pc_target_q, pc_target_d;
    logic           done_q, done_d;
    logic           unused_bits;

`ifdef WB_UART_TIMEOUT_EN
    localparam int CNT_W = $clog2(UART_TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uart_timeout_q, uart_timeout_d;
`endif

    // Next-state, bundle capture and COMMIT output values.
    always_comb begin
        live = '{distinct: wb.distinct, aorf: wb.AorF, reg_write: wb.RegWrite,
                 mem_to_reg: wb.MemtoReg, branch: wb.Branch, uart_to_reg: wb.UARTtoReg,
                 read_data: wb.read_data, register_data: wb.register_data,
                 alu_result: wb.alu_result, rdist: wb.rdist, inst_index: wb.inst_index,
                 pc1: wb.pc1, pc2: wb.pc2};
        state_d       = state_q;
        bundle_d      = bundle_q;
        cur           = bundle_q;
        commit_go     = 1'b0;
        uart_word     = {24'b0, wb.uart_rx_data};
        reg_we_int_d  = 1'b0;
        reg_we_fp_d   = 1'b0;
        pc_redirect_d = 1'b0;
        done_d        = 1'b0;
        reg_waddr_d   = reg_waddr_q;
        reg_wdata_d   = reg_wdata_q;
        pc_target_d   = pc_target_q;
`ifdef WB_UART_TIMEOUT_EN
        cnt_d          = '0;
        uart_timeout_d = uart_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (wb.valid) begin
                    bundle_d = live;
                    cur      = live;
                    if (~live.distinct & live.reg_write & live.uart_to_reg) begin
                        state_d = UART_WAIT;
                    end else begin
                        state_d   = COMMIT;
                        commit_go = 1'b1;
                    end
                end
            end
            UART_WAIT: begin
                // uart_rx_ready is high throughout UART_WAIT, so rx_valid alone completes the handshake.
                if (wb.uart_rx_valid) begin
                    state_d   = COMMIT;
                    commit_go = 1'b1;
                end
`ifdef WB_UART_TIMEOUT_EN
                else if (cnt_q == CNT_W'(UART_TIMEOUT_CYCLES - 1)) begin
                    state_d        = COMMIT;
                    commit_go      = 1'b1;
                    uart_word      = 32'hFFFF_FFFF;
                    uart_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (commit_go) begin
            done_d        = 1'b1;
            reg_we_int_d  = cur.reg_write & ~cur.aorf & ~cur.distinct & (cur.rdist != 5'd0);
            reg_we_fp_d   = cur.reg_write & cur.aorf & ~cur.distinct;
            reg_waddr_d   = cur.rdist;
            if (cur.uart_to_reg) begin
                reg_wdata_d = uart_word;
            end else begin
                case (cur.mem_to_reg)
                    2'b01:   reg_wdata_d = cur.read_data;
                    2'b10:   reg_wdata_d = {{(32-IMW){1'b0}}, cur.pc1};
                    default: reg_wdata_d = cur.alu_result;
                endcase
            end
            pc_redirect_d = ~cur.distinct &
                            (((cur.branch == 2'b01) & cur.alu_result[0]) | cur.branch[1]);
            case (cur.branch)
                2'b01:   pc_target_d = cur.pc2;
                2'b10:   pc_target_d = cur.inst_index[IMW-1:0];
                2'b11:   pc_target_d = cur.register_data[IMW-1:0];
                default: pc_target_d = pc_target_q;
            endcase
        end
    end

    // State, captured bundle and registered outputs; synchronous reset clears everything.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            bundle_q      <= '0;
            reg_we_int_q  <= 1'b0;
            reg_we_fp_q   <= 1'b0;
            reg_waddr_q   <= '0;
            reg_wdata_q   <= '0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= '0;
            done_q        <= 1'b0;
`ifdef WB_UART_TIMEOUT_EN
            cnt_q          <= '0;
            uart_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bundle_q      <= bundle_d;
            reg_we_int_q  <= reg_we_int_d;
            reg_we_fp_q   <= reg_we_fp_d;
            reg_waddr_q   <= reg_waddr_d;
            reg_wdata_q   <= reg_wdata_d;
            pc_redirect_q <= pc_redirect_d;
            pc_target_q   <= pc_target_d;
            done_q        <= done_d;
`ifdef WB_UART_TIMEOUT_EN
            cnt_q          <= cnt_d;
            uart_timeout_q <= uart_timeout_d;
`endif
        end
    end

    assign wb.reg_we_int    = reg_we_int_q;
    assign wb.reg_we_fp     = reg_we_fp_q;
    assign wb.reg_waddr     = reg_waddr_q;
    assign wb.reg_wdata     = reg_wdata_q;
    assign wb.pc_redirect   = pc_redirect_q;
    assign wb.pc_target     = pc_target_q;
    assign wb.done          = done_q;
    assign wb.busy          = (state_q != IDLE);
    assign wb.uart_rx_ready = (state_q == UART_WAIT);

    // pc and the upper target-field bits never reach an output; fold them away explicitly.
`ifdef WB_UART_TIMEOUT_EN
    assign wb.uart_timeout = uart_timeout_q;
    assign unused_bits     = ^{wb.pc, cur.inst_index[25:IMW], cur.register_data[31:IMW]};
`else
    assign wb.uart_timeout = 1'b0;
    assign unused_bits     = ^{wb.pc, cur.inst_index[25:IMW], cur.register_data[31:IMW],
                               32'(UART_TIMEOUT_CYCLES)};
`endif
endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed + randomized retirements checked by a scoreboard.
// Driver pushes expected retirements; a monitor pops and compares whenever done is seen.
// Also covers UART stall, ignored valid while busy, reset mid-wait and optional timeout.
module tb_write_back;
    localparam int IMW = 2;
    localparam int TMO = 8;

    typedef struct {
        bit        distinct, aorf, rw, u2r;
        bit [1:0]  m2r, br;
        bit [31:0] rd, regd, alu;
        bit [4:0]  rdist;
        bit [25:0] ii;
        bit [1:0]  pc, pc1, pc2;
    } stim_t;

    typedef struct {
        bit        we_int, we_fp, redirect;
        bit [4:0]  waddr;
        bit [31:0] wdata;
        bit [1:0]  target;
    } exp_t;

    logic  CLK;
    logic  reset;
    int    total = 0;
    int    bad   = 0;
    exp_t  exp_q[$];

    write_back_if #(.INST_MEM_WIDTH(IMW)) bus ();

    write_back #(.INST_MEM_WIDTH(IMW), .UART_TIMEOUT_CYCLES(TMO)) dut (
        .CLK   (CLK),
        .reset (reset),
        .wb    (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what one retirement should look like, from the architectural rules.
    function automatic exp_t model(input stim_t s, input bit [7:0] rx_byte, input bit tmo);
        exp_t e;
        bit   real_slot = !s.distinct;
        e.we_int   = real_slot && s.rw && !s.aorf && (s.rdist != 0);
        e.we_fp    = real_slot && s.rw && s.aorf;
        e.waddr    = s.rdist;
        if (s.u2r)            e.wdata = tmo ? 32'hFFFF_FFFF : {24'h0, rx_byte};
        else if (s.m2r == 1)  e.wdata = s.rd;
        else if (s.m2r == 2)  e.wdata = {30'h0, s.pc1};
        else                  e.wdata = s.alu;
        e.redirect = real_slot && ((s.br == 1 && s.alu[0]) || s.br >= 2);
        if (s.br == 1)        e.target = s.pc2;
        else if (s.br == 2)   e.target = s.ii[1:0];
        else                  e.target = s.regd[1:0];
        return e;
    endfunction

    function automatic stim_t base();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.distinct = ($urandom_range(0, 5) == 0);
        s.aorf     = $urandom_range(0, 1) == 1;
        s.rw       = $urandom_range(0, 3) != 0;
        s.u2r      = ($urandom_range(0, 3) == 0);
        s.m2r      = 2'($urandom_range(0, 3));
        s.br       = 2'($urandom_range(0, 3));
        s.rd       = $urandom;
        s.regd     = $urandom;
        s.alu      = $urandom;
        s.rdist    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s.ii       = 26'($urandom);
        s.pc       = 2'($urandom_range(0, 3));
        s.pc1      = 2'($urandom_range(0, 3));
        s.pc2      = 2'($urandom_range(0, 3));
        return s;
    endfunction

    task automatic drive_bundle(input stim_t s);
        bus.distinct      = s.distinct;
        bus.AorF          = s.aorf;
        bus.RegWrite      = s.rw;
        bus.UARTtoReg     = s.u2r;
        bus.MemtoReg      = s.m2r;
        bus.Branch        = s.br;
        bus.read_data     = s.rd;
        bus.register_data = s.regd;
        bus.alu_result    = s.alu;
        bus.rdist         = s.rdist;
        bus.inst_index    = s.ii;
        bus.pc            = s.pc;
        bus.pc1           = s.pc1;
        bus.pc2           = s.pc2;
    endtask

    // Issue one slot; returns with the stage back in IDLE, just after a rising edge.
    task automatic run_op(input stim_t s, input int wait_cyc, input bit [7:0] rx_byte, input bit ghost);
        stim_t g;
        bit    uart = !s.distinct && s.rw && s.u2r;
        exp_q.push_back(model(s, rx_byte, 1'b0));
        @(negedge CLK);
        drive_bundle(s);
        bus.valid = 1'b1;
        @(posedge CLK); #1;
        if (!uart) begin
            check("latency_done", bus.done, 1);
            @(negedge CLK);
            bus.valid = 1'b0;
        end else begin
            check("wait_entry_done", bus.done, 0);
            check("wait_entry_ready", bus.uart_rx_ready, 1);
            check("wait_entry_busy", bus.busy, 1);
            @(negedge CLK);
            bus.valid = 1'b0;
            for (int i = 0; i < wait_cyc; i++) begin
                if (ghost && i == 0) begin
                    g = rand_stim();
                    g.rw = 1'b1; g.u2r = 1'b0; g.distinct = 1'b0; g.br = 2'b10;
                    g.rdist = s.rdist ^ 5'h1f;
                    drive_bundle(g);
                    bus.valid = 1'b1;
                end
                @(posedge CLK); #1;
                check("wait_ready", bus.uart_rx_ready, 1);
                check("wait_busy", bus.busy, 1);
                check("wait_no_done", bus.done, 0);
                @(negedge CLK);
                bus.valid = 1'b0;
            end
            bus.uart_rx_valid = 1'b1;
            bus.uart_rx_data  = rx_byte;
            @(posedge CLK); #1;
            check("uart_done", bus.done, 1);
            @(negedge CLK);
            bus.uart_rx_valid = 1'b0;
            bus.uart_rx_data  = 8'($urandom);
        end
        @(posedge CLK); #1;
        check("post_ready", bus.uart_rx_ready, 0);
        check("post_busy", bus.busy, 0);
    endtask

    // Scoreboard monitor: one expected record per done pulse; strobes must be quiet otherwise.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK); #1;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 expected no retirement");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_we_int", bus.reg_we_int, e.we_int);
                    check("sb_we_fp", bus.reg_we_fp, e.we_fp);
                    check("sb_redirect", bus.pc_redirect, e.redirect);
                    if (e.we_int || e.we_fp) begin
                        check("sb_waddr", bus.reg_waddr, e.waddr);
                        check("sb_wdata", bus.reg_wdata, e.wdata);
                    end
                    if (e.redirect) check("sb_target", bus.pc_target, e.target);
                end
            end else begin
                check("idle_strobes", {bus.reg_we_int, bus.reg_we_fp, bus.pc_redirect}, 0);
            end
        end
    end

    initial begin
        stim_t s;
        int    cyc;
        bit    got;
        reset = 1'b1;
        drive_bundle(base());
        bus.valid = 1'b0; bus.uart_rx_valid = 1'b0; bus.uart_rx_data = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_outputs", {bus.reg_we_int, bus.reg_we_fp, bus.pc_redirect, bus.done,
                              bus.busy, bus.uart_rx_ready, bus.uart_timeout}, 0);
        check("rst_waddr", bus.reg_waddr, 0);
        check("rst_wdata", bus.reg_wdata, 0);
        check("rst_target", bus.pc_target, 0);
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK); #1;

        // ALU write, $zero suppression, FP f0 write
        s = base(); s.rw = 1; s.rdist = 5; s.alu = 32'h1234;
        run_op(s, 0, 8'h00, 0);
        s.rdist = 0;
        run_op(s, 0, 8'h00, 0);
        s.aorf = 1;
        run_op(s, 0, 8'h00, 0);
        // Branches: taken cond, not-taken cond, jump, jump-register
        s = base(); s.br = 1; s.alu = 1; s.pc2 = 3;
        run_op(s, 0, 8'h00, 0);
        s.alu = 0;
        run_op(s, 0, 8'h00, 0);
        s = base(); s.br = 2; s.ii = 26'd2;
        run_op(s, 0, 8'h00, 0);
        s = base(); s.br = 3; s.regd = 32'd1;
        run_op(s, 0, 8'h00, 0);
        // Link and load selects
        s = base(); s.rw = 1; s.rdist = 31; s.m2r = 2; s.pc1 = 2; s.alu = 32'hDEAD_BEEF;
        run_op(s, 0, 8'h00, 0);
        s.m2r = 1; s.rd = 32'hCAFE_F00D;
        run_op(s, 0, 8'h00, 0);
        // UART read with 5-cycle stall, then stall with an ignored second valid
        s = base(); s.rw = 1; s.u2r = 1; s.rdist = 7;
        run_op(s, 5, 8'hA5, 0);
        s.rdist = 12;
        run_op(s, 3, 8'h3C, 1);
        // Bubble: no write, no redirect, still retires
        s = base(); s.distinct = 1; s.br = 2; s.rw = 1; s.rdist = 4; s.ii = 26'd3;
        run_op(s, 0, 8'h00, 0);

        for (int n = 0; n < 80; n++) begin
            s = rand_stim();
            run_op(s, $urandom_range(0, 5), 8'($urandom), $urandom_range(0, 1) == 1);
        end

`ifdef WB_UART_TIMEOUT_EN
        s = base(); s.rw = 1; s.u2r = 1; s.rdist = 9;
        exp_q.push_back(model(s, 8'h00, 1'b1));
        @(negedge CLK);
        drive_bundle(s);
        bus.valid = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        bus.valid = 1'b0;
        cyc = 0; got = 0;
        while (!got && cyc < TMO + 4) begin
            @(posedge CLK); #1;
            cyc++;
            if (bus.done === 1'b1) got = 1;
        end
        check("tmo_latency", cyc, TMO);
        check("tmo_flag", bus.uart_timeout, 1);
        @(negedge CLK);
        @(posedge CLK); #1;
        check("tmo_sticky", bus.uart_timeout, 1);
`else
        cyc = 0; got = 0;
        check("tmo_tied_low", bus.uart_timeout, 0);
`endif

        // Reset while parked in UART_WAIT with a byte offered on the reset edge
        s = base(); s.rw = 1; s.u2r = 1; s.rdist = 3;
        @(negedge CLK);
        drive_bundle(s);
        bus.valid = 1'b1;
        @(posedge CLK); #1;
        check("rmw_ready", bus.uart_rx_ready, 1);
        @(negedge CLK);
        bus.valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h77;
        @(posedge CLK); #1;
        check("rmw_flags", {bus.reg_we_int, bus.reg_we_fp, bus.pc_redirect, bus.done,
                            bus.busy, bus.uart_rx_ready, bus.uart_timeout}, 0);
        check("rmw_wdata", bus.reg_wdata, 0);
        check("rmw_waddr", bus.reg_waddr, 0);
        check("rmw_target", bus.pc_target, 0);
        @(negedge CLK);
        reset = 1'b0;
        bus.uart_rx_valid = 1'b0;
        @(posedge CLK); #1;
        check("rmw_idle_busy", bus.busy, 0);

        s = base(); s.rw = 1; s.rdist = 17; s.alu = 32'h0BAD_C0DE;
        run_op(s, 0, 8'h00, 0);

        repeat (3) @(posedge CLK);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
